// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states,
// instruction classes, opcode/funct constants, ALU codes and operand selects.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_IMM,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_BNE,
    CLS_J
  } class_t;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;

  localparam logic [1:0] SRC_REG  = 2'b00;
  localparam logic [1:0] SRC_SEXT = 2'b01;
  localparam logic [1:0] SRC_ZEXT = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  // R-type funct field -> {legal, alu_op}; unknown functs come back illegal.
  function automatic logic [4:0] funct_decode(input logic [5:0] funct);
    logic [4:0] res;
    res = {1'b0, ALU_ADD};
    case (funct)
      FN_ADD, FN_ADDU: res = {1'b1, ALU_ADD};
      FN_SUB, FN_SUBU: res = {1'b1, ALU_SUB};
      FN_AND:          res = {1'b1, ALU_AND};
      FN_OR:           res = {1'b1, ALU_OR};
      FN_XOR:          res = {1'b1, ALU_XOR};
      FN_NOR:          res = {1'b1, ALU_NOR};
      FN_SLT:          res = {1'b1, ALU_SLT};
      FN_SLTU:         res = {1'b1, ALU_SLTU};
      default:         res = {1'b0, ALU_ADD};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational instruction classifier: opcode/funct -> class and the
// EXEC-phase datapath controls (ALU op, operand select, destination select).
module mc_instr_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output class_t     o_cls,
  output logic [3:0] o_alu_op,
  output logic [1:0] o_alu_src,
  output logic       o_reg_dst,
  output logic       o_legal
);

  // Table decode; anything not matched is flagged illegal.
  always_comb begin
    o_cls     = CLS_R;
    o_alu_op  = ALU_ADD;
    o_alu_src = SRC_REG;
    o_reg_dst = 1'b0;
    o_legal   = 1'b1;
    case (i_opcode)
      OP_R: begin
        {o_legal, o_alu_op} = funct_decode(i_funct);
        o_reg_dst           = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        o_cls     = CLS_IMM;
        o_alu_src = SRC_SEXT;
      end
      OP_SLTI: begin
        o_cls     = CLS_IMM;
        o_alu_op  = ALU_SLT;
        o_alu_src = SRC_SEXT;
      end
      OP_ANDI: begin
        o_cls     = CLS_IMM;
        o_alu_op  = ALU_AND;
        o_alu_src = SRC_ZEXT;
      end
      OP_ORI: begin
        o_cls     = CLS_IMM;
        o_alu_op  = ALU_OR;
        o_alu_src = SRC_ZEXT;
      end
      OP_XORI: begin
        o_cls     = CLS_IMM;
        o_alu_op  = ALU_XOR;
        o_alu_src = SRC_ZEXT;
      end
      OP_LUI: begin
        o_cls    = CLS_LUI;
        o_alu_op = ALU_LUI;
      end
      OP_LW: begin
        o_cls     = CLS_LW;
        o_alu_src = SRC_SEXT;
      end
      OP_SW: begin
        o_cls     = CLS_SW;
        o_alu_src = SRC_SEXT;
      end
      OP_BEQ: begin
        o_cls    = CLS_BEQ;
        o_alu_op = ALU_SUB;
      end
      OP_BNE: begin
        o_cls    = CLS_BNE;
        o_alu_op = ALU_SUB;
      end
      OP_J: begin
        o_cls = CLS_J;
      end
      default: begin
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB with
// req/ack handshakes to instruction and data memory, holds the IR and
// counts retired instructions. All control outputs are decoded from the
// current state and IR and are forced low while rst is asserted.
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  input  logic             alu_zero,
  output logic             reg_write,
  output logic             reg_dst,
  output logic [1:0]       alu_src,
  output logic [3:0]       alu_op,
  output logic             mem_to_reg,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_ir;
  logic [CNT_W-1:0] r_count;
  logic             w_load_ir;
  logic             w_retire;

  class_t           w_cls;
  logic [3:0]       w_dec_alu_op;
  logic [1:0]       w_dec_alu_src;
  logic             w_dec_reg_dst;
  logic             w_dec_legal;

  mc_instr_decode u_decode (
    .i_opcode  (r_ir[31:26]),
    .i_funct   (r_ir[5:0]),
    .o_cls     (w_cls),
    .o_alu_op  (w_dec_alu_op),
    .o_alu_src (w_dec_alu_src),
    .o_reg_dst (w_dec_reg_dst),
    .o_legal   (w_dec_legal)
  );

  assign instr       = r_ir;
  assign instr_count = r_count;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Instruction register, loaded on the accepted fetch.
  always_ff @(posedge clk) begin
    if (rst)            r_ir <= 32'd0;
    else if (w_load_ir) r_ir <= imem_rdata;
  end

  // Retired-instruction counter; wraps naturally at all-ones.
  always_ff @(posedge clk) begin
    if (rst)           r_count <= '0;
    else if (w_retire) r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Next-state and output decode; reset masks every strobe and request.
  always_comb begin
    w_next     = r_state;
    w_load_ir  = 1'b0;
    w_retire   = 1'b0;
    imem_req   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src    = SRC_REG;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SEQ;
    illegal    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_load_ir = 1'b1;
          pc_write  = 1'b1;
          pc_src    = PC_SEQ;
          w_next    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_dec_legal) begin
          w_next = ST_EXEC;
        end else begin
          illegal = 1'b1;
          w_next  = ST_FETCH;
        end
      end
      ST_EXEC: begin
        alu_op  = w_dec_alu_op;
        alu_src = w_dec_alu_src;
        reg_dst = w_dec_reg_dst;
        case (w_cls)
          CLS_LW, CLS_SW: w_next = ST_MEM;
          CLS_BEQ: begin
            pc_write = alu_zero;
            pc_src   = PC_BR;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end
          CLS_BNE: begin
            pc_write = ~alu_zero;
            pc_src   = PC_BR;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end
          CLS_J: begin
            pc_write = 1'b1;
            pc_src   = PC_JMP;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end
          default: w_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_cls == CLS_SW);
        if (dmem_ack) begin
          if (w_cls == CLS_SW) begin
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (w_cls == CLS_LW);
        w_retire   = 1'b1;
        w_next     = ST_FETCH;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (rst) begin
      w_load_ir  = 1'b0;
      w_retire   = 1'b0;
      imem_req   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = SRC_REG;
      alu_op     = ALU_ADD;
      mem_to_reg = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SEQ;
      illegal    = 1'b0;
    end
  end

endmodule
